matrix_4x4_mult: RTL and testbench
==================================

# matrix_4x4_mult

Streaming 4×4 integer matrix multiplier computing C = A×B. Operands arrive as 16 paired words (one A element and one B element per beat, column-major) over a valid/ready input handshake. The product is presented as four parallel column buses under a valid/ready output handshake. It is used as a small compute tile between a loader and a result consumer.

## Interface
- `DATA_W`, default 12: element width for A, B and C.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `valid_in` input 1: upstream start/data qualifier.
- `a_in` input DATA_W: A element for the current beat.
- `b_in` input DATA_W: B element for the current beat.
- `ready_out` output 1: block can accept a new job.
- `ready_in` input 1: downstream accepts the held result.
- `valid_out` output 1: result on `cC1`..`cC4` is valid.
- `cC1`..`cC4` output [3:0][DATA_W-1:0]: column j of C; `cCj[i]` = C[i][j-1], with index 0 in the LSBs.

## Operation
- States:
  - IDLE (ready_out=1, valid_out=0).
  - LOAD (ready_out=0).
  - COMPUTE (ready_out=0).
  - DONE (ready_out=1, valid_out=1).
- IDLE/DONE → LOAD on a start beat: the first clock edge with valid_in=1 in IDLE or DONE. a_in/b_in are ignored on that beat. valid_out drops when DONE is left.
- DONE → IDLE on ready_in=1 with valid_in=0. If valid_in=1 in DONE, the start takes priority.
- LOAD captures on every edge with valid_in=1. Word n (0..15) maps to row n%4, column n/4 of both A and B. So the order is A[0][0],A[1][0],A[2][0],A[3][0],A[0][1],… and likewise for B.
- valid_in=0 in LOAD stalls the beat counter; no data is lost. After word 15 the block enters COMPUTE.
- COMPUTE takes 16 cycles and produces one C element per cycle, in the same column-major order. Each element C[i][j] = Σk A[i][k]·B[k][j], computed as 4 products plus an adder tree.
- Products and sums are unsigned and reduced modulo 2^DATA_W (wrap-around) unless saturation is enabled.
- C elements are written directly into the `cC` registers. After 16 cycles the block enters DONE.
- Outputs hold their last value until overwritten, including after valid_out drops.
- ready_in is ignored outside DONE. valid_in is ignored in COMPUTE.

## Timing
- Reset values:
  - state = IDLE
  - ready_out = 1
  - valid_out = 0
  - all cC = 0
  - beat/element counters = 0
  - A/B stores = 0
- Reset mid-LOAD or mid-COMPUTE aborts the job and discards partial data.
- All outputs are registered.
- Latency: valid_out rises 16 clock edges after the edge that captures word 15, provided there is no stall.
- Minimum job length: 1 start beat + 16 data beats + 16 compute cycles, then DONE.
- Back-to-back jobs: in DONE, either assert ready_in then valid_in, or assert valid_in alone.

## Configuration
- `MATRIX_4X4_MULT_SATURATE_EN` defined: each product and each accumulated sum clamps to 2^DATA_W−1 on overflow.
- `MATRIX_4X4_MULT_SATURATE_EN` undefined: arithmetic wraps modulo 2^DATA_W.

## Structure
- Package `matrix_4x4_mult_pkg` holds:
  - constants N=4 and the default DATA_W
  - the element typedef
  - the state enum (IDLE/LOAD/COMPUTE/DONE)
- One sub-module, `matrix_4x4_dot4`: a combinational 4-term dot product. It takes a row of A and a column of B and implements the wrap or saturate rule.
- Top level holds the FSM, counters, A/B register files and cC registers.

## Test plan
- Reset: hold rst_n=0 → ready_out=1, valid_out=0, cC1..cC4 all 0. Release rst_n → ready_out stays 1.
- A and B both have rows of all 1, all 2, all 3, all 4 → after valid_out, each cCj = {10,20,30,40} (index 0..3).
- Second job: pulse ready_in in DONE, then run A = all 1, B = identity → valid_out drops, then rises with every C element = 1. Latency is 16 cycles after the last word.
- Overflow: A and B all 4095 → every C element = 4 with saturation off, and 4095 with `MATRIX_4X4_MULT_SATURATE_EN` defined.
- Stall: drop valid_in for 3 cycles after word 5 of the first-job operands → same result as the first-job case, with valid_out 3 cycles later.
- Abort: assert rst_n=0 during COMPUTE → block returns to reset values. A following full job produces the correct result.

Source files
------------

// File: rtl/matrix_4x4_mult_pkg.sv
// Shared constants, element type and FSM state encoding for the 4x4 matrix multiplier.
package matrix_4x4_mult_pkg;
    localparam int N          = 4;
    localparam int DATA_W_DEF = 12;

    typedef logic [DATA_W_DEF-1:0] elem_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/matrix_4x4_dot4.sv
// Combinational 4-term dot product of an A row and a B column.
// Wraps modulo 2^DATA_W, or clamps every product and partial sum when MATRIX_4X4_MULT_SATURATE_EN is defined.
module matrix_4x4_dot4
    import matrix_4x4_mult_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [N-1:0][DATA_W-1:0] a_row,
    input  logic [N-1:0][DATA_W-1:0] b_col,
    output logic [DATA_W-1:0]        dot
);
    localparam logic [DATA_W-1:0] MAX_VAL = '1;

    logic [N-1:0][DATA_W-1:0] prod;
    logic [DATA_W-1:0]        sum_lo;
    logic [DATA_W-1:0]        sum_hi;

    function automatic logic [DATA_W-1:0] add_rule(input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
`ifdef MATRIX_4X4_MULT_SATURATE_EN
        logic [DATA_W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[DATA_W] ? MAX_VAL : s[DATA_W-1:0];
`else
        return x + y;
`endif
    endfunction

    for (genvar gi = 0; gi < N; gi++) begin : g_prod
`ifdef MATRIX_4X4_MULT_SATURATE_EN
        logic [2*DATA_W-1:0] full;
        assign full     = {{DATA_W{1'b0}}, a_row[gi]} * {{DATA_W{1'b0}}, b_col[gi]};
        assign prod[gi] = (|full[2*DATA_W-1:DATA_W]) ? MAX_VAL : full[DATA_W-1:0];
`else
        assign prod[gi] = a_row[gi] * b_col[gi];
`endif
    end

    // Balanced adder tree: (p0+p1) + (p2+p3)
    assign sum_lo = add_rule(prod[0], prod[1]);
    assign sum_hi = add_rule(prod[2], prod[3]);
    assign dot    = add_rule(sum_lo, sum_hi);
endmodule

// File: rtl/matrix_4x4_mult.sv
// Streaming 4x4 matrix multiplier C = A x B: column-major operand load, one C element per compute cycle.
// Optional saturation via MATRIX_4X4_MULT_SATURATE_EN (handled in matrix_4x4_dot4).
module matrix_4x4_mult
    import matrix_4x4_mult_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic [DATA_W-1:0]        a_in,
    input  logic [DATA_W-1:0]        b_in,
    output logic                     ready_out,
    input  logic                     ready_in,
    output logic                     valid_out,
    output logic [N-1:0][DATA_W-1:0] cC1,
    output logic [N-1:0][DATA_W-1:0] cC2,
    output logic [N-1:0][DATA_W-1:0] cC3,
    output logic [N-1:0][DATA_W-1:0] cC4
);
    state_t state_reg, state_next;
    logic [3:0] beat_reg;
    logic [3:0] elem_reg;

    // a_store[row][col] = A[row][col]; b_store/c_store are held per column: x_store[col][row]
    logic [N-1:0][DATA_W-1:0] a_store [N];
    logic [N-1:0][DATA_W-1:0] b_store [N];
    logic [N-1:0][DATA_W-1:0] c_store [N];
    logic [DATA_W-1:0]        dot;

    logic [1:0] beat_row, beat_col, elem_row, elem_col;
    assign beat_row = beat_reg[1:0];
    assign beat_col = beat_reg[3:2];
    assign elem_row = elem_reg[1:0];
    assign elem_col = elem_reg[3:2];

    matrix_4x4_dot4 #(.DATA_W(DATA_W)) u_dot (
        .a_row (a_store[elem_row]),
        .b_col (b_store[elem_col]),
        .dot   (dot)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (valid_in) state_next = LOAD;
            LOAD:    if (valid_in && beat_reg == 4'd15) state_next = COMPUTE;
            COMPUTE: if (elem_reg == 4'd15) state_next = DONE;
            DONE: begin
                if (valid_in)      state_next = LOAD;
                else if (ready_in) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ready_out <= 1'b1;
            valid_out <= 1'b0;
            beat_reg  <= '0;
            elem_reg  <= '0;
            for (int r = 0; r < N; r++) begin
                a_store[r] <= '0;
                b_store[r] <= '0;
                c_store[r] <= '0;
            end
        end else begin
            state_reg <= state_next;
            ready_out <= (state_next == IDLE) || (state_next == DONE);
            valid_out <= (state_next == DONE);
            // Counters wrap to zero at the end of each phase, so a new job always starts at 0
            if (state_reg == LOAD && valid_in) begin
                a_store[beat_row][beat_col] <= a_in;
                b_store[beat_col][beat_row] <= b_in;
                beat_reg                    <= beat_reg + 4'd1;
            end
            if (state_reg == COMPUTE) begin
                c_store[elem_col][elem_row] <= dot;
                elem_reg                    <= elem_reg + 4'd1;
            end
        end
    end

    assign cC1 = c_store[0];
    assign cC2 = c_store[1];
    assign cC3 = c_store[2];
    assign cC4 = c_store[3];
endmodule

// File: tb/tb_matrix_4x4_mult.sv
// Self-checking bench for matrix_4x4_mult: directed and randomized jobs against a plain-arithmetic matrix model.
module tb_matrix_4x4_mult;
    localparam int W    = 12;
    localparam int MAXV = 4095;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_in = 1'b0;
    logic          ready_in = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          ready_out, valid_out;
    logic [3:0][W-1:0] cC1, cC2, cC3, cC4;

    int tests_run = 0;
    int tests_failed = 0;
    int ma [4][4];
    int mb [4][4];
    int exp_c [4][4];
    int lat, total;

    matrix_4x4_mult #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .ready_out (ready_out),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .cC1       (cC1),
        .cC2       (cC2),
        .cC3       (cC3),
        .cC4       (cC4)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] c_out(input int i, input int j);
        case (j)
            0:       return cC1[i];
            1:       return cC2[i];
            2:       return cC3[i];
            default: return cC4[i];
        endcase
    endfunction

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], then wrap or clamp
    function automatic void model();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int acc;
                acc = 0;
                for (int k = 0; k < 4; k++) begin
                    int p;
                    p = ma[i][k] * mb[k][j];
`ifdef MATRIX_4X4_MULT_SATURATE_EN
                    if (p > MAXV) p = MAXV;
`endif
                    acc += p;
                end
`ifdef MATRIX_4X4_MULT_SATURATE_EN
                exp_c[i][j] = (acc > MAXV) ? MAXV : acc;
`else
                exp_c[i][j] = acc % (MAXV + 1);
`endif
            end
    endfunction

    // Drives a whole job from just after a clock edge; returns latency after word 15 and total edges.
    task automatic run_job(input int stall_after, input int stall_len);
        valid_in = 1'b1;
        a_in = W'($urandom_range(MAXV));
        b_in = W'($urandom_range(MAXV));
        @(posedge clk); #1;
        total = 1;
        tests_run++;
        if (ready_out !== 1'b0 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL start_beat: ready_out=%b valid_out=%b expected 0/0", ready_out, valid_out);
        end
        for (int n = 0; n < 16; n++) begin
            if (n == stall_after + 1 && stall_len > 0) begin
                valid_in = 1'b0;
                a_in = W'($urandom_range(MAXV));
                repeat (stall_len) @(posedge clk);
                #1;
                total += stall_len;
            end
            valid_in = 1'b1;
            a_in = W'(ma[n % 4][n / 4]);
            b_in = W'(mb[n % 4][n / 4]);
            @(posedge clk); #1;
            total++;
        end
        valid_in = 1'b0;
        a_in = W'($urandom_range(MAXV));
        b_in = W'($urandom_range(MAXV));
        lat = 0;
        while (valid_out !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        total += lat;
        if (lat >= 200) begin
            tests_failed++;
            $display("FAIL timeout: valid_out not seen after %0d cycles, required 16", lat);
        end
        model();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: ready_out=%b valid_out=%b expected 1/0", ready_out, valid_out);
        end
        tests_run++;
        if ({cC1, cC2, cC3, cC4} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0", {cC1, cC2, cC3, cC4});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL after_reset: ready_out=%b valid_out=%b expected 1/0", ready_out, valid_out);
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = i + 1;
                mb[i][j] = i + 1;
            end
        run_job(99, 0);
        tests_run++;
        if (lat !== 16 || total !== 33) begin
            tests_failed++;
            $display("FAIL ramp_latency: got lat=%0d total=%0d expected 16/33", lat, total);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (c_out(i, j) !== W'((i + 1) * 10) || exp_c[i][j] !== (i + 1) * 10) begin
                    tests_failed++;
                    $display("FAIL ramp C[%0d][%0d]: got %0d expected %0d", i, j, c_out(i, j), (i + 1) * 10);
                end
            end
        $display("[TB] ramp job done, latency %0d", lat);
    endtask

    task automatic test_identity();
        ready_in = 1'b1;
        @(posedge clk); #1;
        ready_in = 1'b0;
        tests_run++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_to_idle: valid_out=%b ready_out=%b expected 0/1", valid_out, ready_out);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = 1;
                mb[i][j] = (i == j) ? 1 : 0;
            end
        run_job(99, 0);
        tests_run++;
        if (lat !== 16) begin
            tests_failed++;
            $display("FAIL identity_latency: got %0d expected 16", lat);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (c_out(i, j) !== W'(1)) begin
                    tests_failed++;
                    $display("FAIL identity C[%0d][%0d]: got %0d expected 1", i, j, c_out(i, j));
                end
            end
        $display("[TB] identity job done, latency %0d", lat);
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = MAXV;
                mb[i][j] = MAXV;
            end
        run_job(99, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (c_out(i, j) !== W'(exp_c[i][j])) begin
                    tests_failed++;
                    $display("FAIL overflow C[%0d][%0d]: got %0d expected %0d", i, j, c_out(i, j), exp_c[i][j]);
                end
            end
        $display("[TB] overflow job done, C[0][0] expected %0d", exp_c[0][0]);
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = i + 1;
                mb[i][j] = i + 1;
            end
        run_job(5, 3);
        tests_run++;
        if (lat !== 16 || total !== 36) begin
            tests_failed++;
            $display("FAIL stall_latency: got lat=%0d total=%0d expected 16/36", lat, total);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (c_out(i, j) !== W'((i + 1) * 10)) begin
                    tests_failed++;
                    $display("FAIL stall C[%0d][%0d]: got %0d expected %0d", i, j, c_out(i, j), (i + 1) * 10);
                end
            end
        $display("[TB] stalled job done, total %0d cycles", total);
    endtask

    task automatic test_abort();
        valid_in = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 16; n++) begin
            a_in = W'($urandom_range(MAXV));
            b_in = W'($urandom_range(MAXV));
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (ready_out !== 1'b1 || valid_out !== 1'b0 || {cC1, cC2, cC3, cC4} !== '0) begin
            tests_failed++;
            $display("FAIL abort_reset: ready_out=%b valid_out=%b c=%h expected 1/0/0",
                     ready_out, valid_out, {cC1, cC2, cC3, cC4});
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tests_run++;
        if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_resume: valid_out=%b ready_out=%b expected 0/1", valid_out, ready_out);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = $urandom_range(MAXV);
                mb[i][j] = $urandom_range(MAXV);
            end
        run_job(99, 0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tests_run++;
                if (c_out(i, j) !== W'(exp_c[i][j])) begin
                    tests_failed++;
                    $display("FAIL abort_next C[%0d][%0d]: got %0d expected %0d", i, j, c_out(i, j), exp_c[i][j]);
                end
            end
        $display("[TB] abort and recovery job done");
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 5; t++) begin
            int sa, sl;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ma[i][j] = (t % 2 == 0) ? $urandom_range(MAXV) : $urandom_range(15);
                    mb[i][j] = (t % 2 == 0) ? $urandom_range(MAXV) : $urandom_range(15);
                end
            sa = $urandom_range(14);
            sl = $urandom_range(3);
            run_job(sa, sl);
            tests_run++;
            if (lat !== 16 || total !== 33 + sl) begin
                tests_failed++;
                $display("FAIL b2b%0d_latency: got lat=%0d total=%0d expected 16/%0d", t, lat, total, 33 + sl);
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    tests_run++;
                    if (c_out(i, j) !== W'(exp_c[i][j])) begin
                        tests_failed++;
                        $display("FAIL b2b%0d C[%0d][%0d]: got %0d expected %0d", t, i, j, c_out(i, j), exp_c[i][j]);
                    end
                end
            $display("[TB] random job %0d done, stall %0d after word %0d", t, sl, sa);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_identity();
        test_overflow();
        test_stall();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
